// File: rtl/serial_pattern_scan_ctrl.sv
// -----------------------------------------------------------------------------
// serial_pattern_scan_ctrl
//
// Purpose:
//   Takes parallel words over a valid/ready handshake. Each word is fed into an
//   embedded Moore "10010" detector, MSB first, one bit per clock. The module
//   counts the detector hits in the word and returns the count over a
//   valid/ready result handshake.
//
// Handshake semantics (both ports):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   A producer holds valid (and data) until that edge. Ready may depend on
//   state only, never on valid.
//
// Parameters:
//   WORD_W - bits per input word (>= 2)
//   CNT_W  - width of the saturating per-word hit counter
//
// Ports:
//   clk, rst      - clock; synchronous active-high reset
//   in_valid      - producer offers in_word
//   in_ready      - controller is IDLE and can accept a word
//   in_word       - word to scan; bit WORD_W-1 is consumed first
//   keep_ctx      - sampled at acceptance; 0 restarts the detector at S0
//   out_valid     - result available (DONE)
//   out_ready     - consumer takes the result
//   out_hits      - hits counted in the scanned word (saturating)
//   busy          - high in SHIFT or DONE
//   det_state     - current detector state (0..5), for debug
//
// Optional feature (macro SCAN_FIRST_POS_EN):
//   out_any_hit   - at least one hit occurred in the word
//   out_first_pos - consumption index (0 = MSB) of the bit that caused the
//                   first hit. Both outputs are cleared at reset and at
//                   acceptance, and are valid together with out_valid.
// -----------------------------------------------------------------------------
module serial_pattern_scan_ctrl #(
   parameter int WORD_W = 8,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_word,
   input  logic              keep_ctx,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  out_hits,
   output logic              busy,
   output logic [2:0]        det_state
`ifdef SCAN_FIRST_POS_EN
   ,
   output logic                      out_any_hit,
   output logic [$clog2(WORD_W)-1:0] out_first_pos
`endif
);

   localparam int BW = $clog2(WORD_W);
   localparam logic [BW-1:0] LAST_BIT = BW'(WORD_W - 1);

   localparam logic [2:0] S0 = 3'd0;
   localparam logic [2:0] S1 = 3'd1;
   localparam logic [2:0] S2 = 3'd2;
   localparam logic [2:0] S3 = 3'd3;
   localparam logic [2:0] S4 = 3'd4;
   localparam logic [2:0] S5 = 3'd5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } ctrl_t;

   ctrl_t             state;
   logic [WORD_W-1:0] word_q;
   logic [BW-1:0]     bit_cnt;
   logic [CNT_W-1:0]  hit_cnt;
   logic [2:0]        det_q;
   logic              in_ready_q;
   logic              out_valid_q;
   logic              busy_q;
`ifdef SCAN_FIRST_POS_EN
   logic              any_hit_q;
   logic [BW-1:0]     first_pos_q;
`endif

   // Detector next-state function. Encodings 6 and 7 recover to S0.
   function automatic logic [2:0] det_next_f(input logic [2:0] s, input logic b);
      logic [2:0] n;
      n = S0;
      case (s)
         S0: n = b ? S1 : S0;
         S1: n = b ? S1 : S2;
         S2: n = b ? S1 : S3;
         S3: n = b ? S4 : S0;
         S4: n = b ? S1 : S5;
         S5: n = b ? S1 : S3;
         default: n = S0;
      endcase
      return n;
   endfunction

   // The word register shifts left each SHIFT cycle, so the bit being consumed
   // is always the MSB: word[WORD_W-1-bit_cnt] of the originally latched word.
   logic       cur_bit;
   logic [2:0] det_nxt;
   logic       hit;

   always_comb begin
      cur_bit = word_q[WORD_W-1];
      det_nxt = det_next_f(det_q, cur_bit);
      hit     = (det_nxt == S5);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         word_q      <= '0;
         bit_cnt     <= '0;
         hit_cnt     <= '0;
         det_q       <= S0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef SCAN_FIRST_POS_EN
         any_hit_q   <= 1'b0;
         first_pos_q <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  word_q      <= in_word;
                  bit_cnt     <= '0;
                  hit_cnt     <= '0;
                  if (!keep_ctx) det_q <= S0;
                  in_ready_q  <= 1'b0;
                  busy_q      <= 1'b1;
                  state       <= SHIFT;
`ifdef SCAN_FIRST_POS_EN
                  any_hit_q   <= 1'b0;
                  first_pos_q <= '0;
`endif
               end
            end
            SHIFT: begin
               det_q   <= det_nxt;
               word_q  <= {word_q[WORD_W-2:0], 1'b0};
               bit_cnt <= bit_cnt + 1'b1;
               // The hit is counted on the same edge as the bit that causes it.
               if (hit && (hit_cnt != {CNT_W{1'b1}})) hit_cnt <= hit_cnt + 1'b1;
`ifdef SCAN_FIRST_POS_EN
               if (hit && !any_hit_q) begin
                  any_hit_q   <= 1'b1;
                  first_pos_q <= bit_cnt;
               end
`endif
               if (bit_cnt == LAST_BIT) begin
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               in_ready_q  <= 1'b1;
               state       <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign out_hits  = hit_cnt;
   assign det_state = det_q;
`ifdef SCAN_FIRST_POS_EN
   assign out_any_hit   = any_hit_q;
   assign out_first_pos = first_pos_q;
`endif

endmodule

// File: tb/tb_serial_pattern_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_pattern_scan_ctrl
//
// Directed bench for serial_pattern_scan_ctrl. Instance a uses the defaults
// (WORD_W=8, CNT_W=4). Instance b (WORD_W=16, CNT_W=2) covers counter
// saturation. Expected values are hand-derived from the detector table.
// -----------------------------------------------------------------------------
module tb_serial_pattern_scan_ctrl;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- instance a: 8-bit words ----------------
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_word  = '0;
   logic       keep_ctx = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [3:0] out_hits;
   logic       busy;
   logic [2:0] det_state;
`ifdef SCAN_FIRST_POS_EN
   logic       out_any_hit;
   logic [2:0] out_first_pos;
`endif

   serial_pattern_scan_ctrl #(.WORD_W(8), .CNT_W(4)) dut_a (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word), .keep_ctx(keep_ctx),
      .out_valid(out_valid), .out_ready(out_ready), .out_hits(out_hits),
      .busy(busy), .det_state(det_state)
`ifdef SCAN_FIRST_POS_EN
      , .out_any_hit(out_any_hit), .out_first_pos(out_first_pos)
`endif
   );

   // ---------------- instance b: 16-bit words, 2-bit counter ----------------
   logic        b_in_valid = 1'b0;
   logic        b_in_ready;
   logic [15:0] b_in_word  = '0;
   logic        b_keep_ctx = 1'b0;
   logic        b_out_valid;
   logic        b_out_ready = 1'b0;
   logic [1:0]  b_out_hits;
   logic        b_busy;
   logic [2:0]  b_det_state;
`ifdef SCAN_FIRST_POS_EN
   logic        b_out_any_hit;
   logic [3:0]  b_out_first_pos;
`endif

   serial_pattern_scan_ctrl #(.WORD_W(16), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_word(b_in_word), .keep_ctx(b_keep_ctx),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_hits(b_out_hits),
      .busy(b_busy), .det_state(b_det_state)
`ifdef SCAN_FIRST_POS_EN
      , .out_any_hit(b_out_any_hit), .out_first_pos(b_out_first_pos)
`endif
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;
   logic [3:0] exp_q[$];

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- driver: one word through instance a ----------------
   // hold: cycles to keep out_ready low in DONE while poking in_valid.
   task automatic run_word(input string tag, input logic [7:0] word, input logic keep,
                           input logic [3:0] exp_hits, input logic [2:0] exp_state,
                           input logic exp_any, input logic [2:0] exp_first,
                           input int hold);
      int cyc;
      logic [3:0] exp_h;
      logic [3:0] held_hits;
      exp_q.push_back(exp_hits);
      cyc = 0;
      while (!in_ready && cyc < 20) begin
         tick();
         cyc++;
      end
      check({tag, "_in_ready"}, int'(in_ready), 1);
      in_word  = word;
      keep_ctx = keep;
      in_valid = 1'b1;
      tick();                      // acceptance edge k
      in_valid = 1'b0;
      in_word  = $urandom_range(0, 255);
      keep_ctx = $urandom_range(0, 1);
      check({tag, "_busy"}, int'(busy), 1);
      cyc = 0;
      while (!out_valid && cyc < 40) begin
         tick();
         cyc++;
      end
      check({tag, "_latency"}, cyc, 8);
      exp_h = (exp_q.size() > 0) ? exp_q.pop_front() : 4'd0;
      check({tag, "_hits"}, int'(out_hits), int'(exp_h));
      check({tag, "_det_state"}, int'(det_state), int'(exp_state));
`ifdef SCAN_FIRST_POS_EN
      check({tag, "_any_hit"}, int'(out_any_hit), int'(exp_any));
      check({tag, "_first_pos"}, int'(out_first_pos), int'(exp_first));
`else
      if (exp_any === 1'bx || exp_first === 3'bxxx) $display("note: unused expectation");
`endif
      held_hits = out_hits;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'(i % 2);
         in_word  = 8'b10010010;
         tick();
         check({tag, "_hold_valid"}, int'(out_valid), 1);
         check({tag, "_hold_hits"}, int'(out_hits), int'(held_hits));
         check({tag, "_hold_in_ready"}, int'(in_ready), 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_release_valid"}, int'(out_valid), 0);
      check({tag, "_release_in_ready"}, int'(in_ready), 1);
      check({tag, "_release_busy"}, int'(busy), 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int cyc;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_hits", int'(out_hits), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_det_state", int'(det_state), 0);
`ifdef SCAN_FIRST_POS_EN
      check("rst_any_hit", int'(out_any_hit), 0);
      check("rst_first_pos", int'(out_first_pos), 0);
`endif
      rst = 1'b0;

      // Basic word: hits at bits 4 and 7, ends in S5.
      run_word("w10010010", 8'b10010010, 1'b0, 4'd2, 3'd5, 1'b1, 3'd4, 0);
      // No-hit words.
      run_word("w00", 8'h00, 1'b0, 4'd0, 3'd0, 1'b0, 3'd0, 0);
      run_word("wff", 8'hFF, 1'b0, 4'd0, 3'd1, 1'b0, 3'd0, 0);
      // Context carry: first word leaves detector in S4.
      run_word("ctx_a", 8'b00001001, 1'b0, 4'd0, 3'd4, 1'b0, 3'd0, 0);
      run_word("ctx_keep", 8'b01111111, 1'b1, 4'd1, 3'd1, 1'b1, 3'd0, 0);
      run_word("ctx_a2", 8'b00001001, 1'b0, 4'd0, 3'd4, 1'b0, 3'd0, 0);
      run_word("ctx_clr", 8'b01111111, 1'b0, 4'd0, 3'd1, 1'b0, 3'd0, 0);
      // Backpressure: out_ready low for 5 cycles in DONE.
      run_word("bp", 8'b10010010, 1'b0, 4'd2, 3'd5, 1'b1, 3'd4, 5);

      // Reset during SHIFT: accept, then rst sampled at the 4th SHIFT edge.
      in_word  = 8'b10010010;
      keep_ctx = 1'b0;
      in_valid = 1'b1;
      tick();                      // acceptance edge k
      in_valid = 1'b0;
      repeat (3) tick();           // edges k+1..k+3, detector now in S3
      check("pre_rst_det_state", int'(det_state), 3);
      rst = 1'b1;
      tick();                      // edge k+4 applies reset
      rst = 1'b0;
      check("mid_rst_in_ready", int'(in_ready), 1);
      check("mid_rst_out_valid", int'(out_valid), 0);
      check("mid_rst_det_state", int'(det_state), 0);
      check("mid_rst_busy", int'(busy), 0);
      // keep_ctx=1 here: the reset must have left the detector at S0.
      run_word("post_rst", 8'b10010010, 1'b1, 4'd2, 3'd5, 1'b1, 3'd4, 0);

      // Saturation on instance b: 4 raw hits, 2-bit counter.
      b_in_word  = 16'b1001001001001001;
      b_keep_ctx = 1'b0;
      b_in_valid = 1'b1;
      tick();
      b_in_valid = 1'b0;
      cyc = 0;
      while (!b_out_valid && cyc < 60) begin
         tick();
         cyc++;
      end
      check("sat_latency", cyc, 16);
      check("sat_hits", int'(b_out_hits), 3);
      check("sat_det_state", int'(b_det_state), 4);
`ifdef SCAN_FIRST_POS_EN
      check("sat_any_hit", int'(b_out_any_hit), 1);
      check("sat_first_pos", int'(b_out_first_pos), 4);
`endif
      b_out_ready = 1'b1;
      tick();
      b_out_ready = 1'b0;
      check("sat_release_in_ready", int'(b_in_ready), 1);
      check("sat_release_busy", int'(b_busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global time limit so the run always terminates.
   initial begin
      #200000;
      n_errors++;
      $display("FAIL timeout: simulation did not finish within time limit");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/serial_pattern_scan_ctrl.md
Name: serial_pattern_scan_ctrl

Overview:
- Sequencing controller for the bit-serial "10010" Moore pattern detector.
- Accepts parallel words over a valid/ready handshake and feeds them into an embedded 6-state detector, MSB first, one bit per clock.
- Counts detector hits per word and returns the count over a valid/ready result handshake.
- Sits between a word-oriented producer and the serial detection datapath.

Parameters:
- WORD_W, 8, bits per input word; legal range 2 or more.
- CNT_W, 4, width of the per-word hit counter; the counter saturates.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  producer offers in_word.
- in_ready  out  1  controller can accept a word.
- in_word  in  WORD_W  word to scan; bit WORD_W-1 is consumed first.
- keep_ctx  in  1  sampled at acceptance. 1 = detector state carries over from the previous word. 0 = detector restarts at S0.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_hits  out  CNT_W  hits counted in the scanned word.
- busy  out  1  high in SHIFT or DONE.
- det_state  out  3  current detector state encoding, for debug.

Behaviour:
- Reset (synchronous, when rst=1 at a rising edge):
  - ctrl state -> IDLE; detector -> S0; bit counter and hit counter -> 0; word register -> 0.
  - Outputs after reset: in_ready=1, out_valid=0, out_hits=0, busy=0, det_state=0.
  - rst overrides everything, including mid-SHIFT and DONE; any in-flight word and result are discarded.
- Controller FSM (IDLE, SHIFT, DONE):
  - IDLE: in_ready=1. If in_valid=1 at an edge: latch in_word, clear the bit and hit counters, go to SHIFT. If keep_ctx=0, the detector is also forced to S0 at that same edge.
  - SHIFT: in_ready=0. Each edge consumes one bit, word[WORD_W-1-bit_cnt], into the detector and increments bit_cnt. The edge that consumes bit WORD_W-1 moves the FSM to DONE.
  - DONE: out_valid=1 and out_hits is held stable. On an edge with out_ready=1, go to IDLE.
  - in_ready=0 in DONE, so there is a minimum of one IDLE cycle between words.
- Latency:
  - Word accepted at edge k; bit i is consumed at edge k+1+i.
  - out_valid rises after edge k+WORD_W.
  - Minimum throughput: one word per WORD_W+2 cycles.
- Detector (Moore, states S0..S5 encoded 0..5; input b):
  - S0: b=1 -> S1, b=0 -> S0.
  - S1: b=1 -> S1, b=0 -> S2.
  - S2: b=1 -> S1, b=0 -> S3.
  - S3: b=1 -> S4, b=0 -> S0.
  - S4: b=1 -> S1, b=0 -> S5.
  - S5: b=1 -> S1, b=0 -> S3.
  - Encodings 6 and 7 -> S0.
  - The detector advances only in SHIFT; otherwise it holds, except for the keep_ctx=0 clear at acceptance.
- Hit counting:
  - A hit is an entry into S5 (next state == S5 while in SHIFT). Overlapping matches count.
  - The hit counter increments on the same edge as the bit that causes the hit, so a hit on the last bit is included in out_hits.
  - Saturates at 2^CNT_W-1; never wraps.
- Handshake rules:
  - in_valid outside IDLE is ignored; the word is not accepted.
  - out_ready outside DONE has no effect.
  - in_word and keep_ctx are don't-care except at the acceptance edge.

Optional Feature:
- Macro: SCAN_FIRST_POS_EN.
- Defined: adds outputs out_any_hit (1 bit) and out_first_pos ($clog2(WORD_W) bits).
  - out_first_pos = index i (consumption order, 0 = MSB) of the bit causing the first hit of the word.
  - Both outputs are valid with out_valid.
  - Both are 0 at reset and when there are no hits.
  - Both are cleared at acceptance.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset then in_word=8'b10010010, keep_ctx=0 -> out_valid exactly 8 cycles after the acceptance edge; out_hits=2; det_state=5 in DONE; with SCAN_FIRST_POS_EN, out_any_hit=1 and out_first_pos=4.
- in_word=8'h00, then 8'hFF, both with keep_ctx=0 -> out_hits=0 for each; out_any_hit=0.
- Context carry: 8'b00001001 (keep_ctx=0) gives out_hits=0, final state S4. Then 8'b01111111 with keep_ctx=1 -> out_hits=1. Repeat the second word with keep_ctx=0 -> out_hits=0.
- Saturation, WORD_W=16, CNT_W=2: 16'b1001001001001001 -> 4 raw hits, out_hits=3.
- Backpressure: out_ready held at 0 for 5 cycles in DONE -> out_valid and out_hits stable, in_ready=0, in_valid pulses ignored. Release -> IDLE next cycle, in_ready=1.
- rst asserted at the 4th SHIFT cycle -> next cycle IDLE, out_valid=0, det_state=0. The following word 8'b10010010 still yields out_hits=2.
